// File: rtl/sram_stage_sequencer.sv
// Top-level sequencer: loads SRAM over UART, runs each enabled stage in index order,
// then hands SRAM back to VGA. Adds skip mask, per-stage watchdog and run-without-load.
module sram_stage_sequencer #(
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned ADDR_W          = 18,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned TIMER_W         = 26,
    parameter int unsigned UART_TIMEOUT    = 50000000,
    parameter int unsigned STAGE_WD_CYCLES = 0
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         Load_req,
    input  logic                         Run_req,
    input  logic [NUM_STAGES-1:0]        Stage_enable_mask,
    output logic                         UART_rx_initialize,
    output logic                         UART_rx_enable,
    input  logic [ADDR_W-1:0]            UART_SRAM_address,
    input  logic [DATA_W-1:0]            UART_SRAM_write_data,
    input  logic                         UART_SRAM_we_n,
    output logic [NUM_STAGES-1:0]        Stage_start,
    input  logic [NUM_STAGES-1:0]        Stage_stop,
    input  logic [NUM_STAGES*ADDR_W-1:0] Stage_SRAM_address,
    input  logic [NUM_STAGES*DATA_W-1:0] Stage_SRAM_write_data,
    input  logic [NUM_STAGES-1:0]        Stage_SRAM_we_n,
    input  logic [ADDR_W-1:0]            VGA_SRAM_address,
    output logic                         VGA_enable,
    output logic [ADDR_W-1:0]            SRAM_address,
    output logic [DATA_W-1:0]            SRAM_write_data,
    output logic                         SRAM_we_n,
    output logic [2:0]                   Active_stage,
    output logic                         Busy,
    output logic                         Stage_timeout_error,
    output logic [2:0]                   Error_stage,
    output logic [2:0]                   State_code
);

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_ENABLE_UART_RX = 3'd1,
        S_WAIT_UART_RX   = 3'd2,
        S_STAGE_SELECT   = 3'd3,
        S_STAGE_WAIT     = 3'd4
    } state_t;

    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [3:0] END_IDX = 4'(NUM_STAGES);
    localparam logic [TIMER_W-1:0] UART_LIMIT = TIMER_W'(UART_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] WD_LIMIT =
        TIMER_W'((STAGE_WD_CYCLES == 0) ? 0 : STAGE_WD_CYCLES - 1);
    localparam logic WD_ON = (STAGE_WD_CYCLES != 0);

    state_t               state;
    logic [3:0]           stage_idx;  // one bit wider than Active_stage so NUM_STAGES=8 can end
    logic [TIMER_W-1:0]   uart_timer;
    logic [TIMER_W-1:0]   wd_timer;
    logic                 sel_valid;
    logic [IDX_W-1:0]     sel;

    logic [ADDR_W-1:0] st_addr [NUM_STAGES];
    logic [DATA_W-1:0] st_data [NUM_STAGES];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_unpack
        assign st_addr[i] = Stage_SRAM_address[i*ADDR_W +: ADDR_W];
        assign st_data[i] = Stage_SRAM_write_data[i*DATA_W +: DATA_W];
    end

    assign sel_valid    = (stage_idx < END_IDX);
    assign sel          = sel_valid ? stage_idx[IDX_W-1:0] : '0;
    assign Active_stage = stage_idx[2:0];
    assign Busy         = (state != S_IDLE);
    assign State_code   = state;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state               <= S_IDLE;
            stage_idx           <= '0;
            uart_timer          <= '0;
            wd_timer            <= '0;
            UART_rx_initialize  <= 1'b0;
            UART_rx_enable      <= 1'b0;
            Stage_start         <= '0;
            VGA_enable          <= 1'b1;
            Stage_timeout_error <= 1'b0;
            Error_stage         <= '0;
        end else begin
            UART_rx_initialize <= 1'b0;
            UART_rx_enable     <= 1'b0;
            Stage_start        <= '0;

            if (UART_rx_initialize || !UART_SRAM_we_n) begin
                uart_timer <= '0;
            end else if (!(&uart_timer)) begin
                uart_timer <= uart_timer + 1'b1;
            end

            if (state == S_STAGE_WAIT && !(&wd_timer)) begin
                wd_timer <= wd_timer + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    VGA_enable <= 1'b1;
                    if (Load_req) begin
                        UART_rx_initialize  <= 1'b1;
                        VGA_enable          <= 1'b0;
                        Stage_timeout_error <= 1'b0;
                        state               <= S_ENABLE_UART_RX;
                    end else if (Run_req) begin
                        VGA_enable          <= 1'b0;
                        Stage_timeout_error <= 1'b0;
                        stage_idx           <= '0;
                        state               <= S_STAGE_SELECT;
                    end
                end
                S_ENABLE_UART_RX: begin
                    UART_rx_enable <= 1'b1;
                    state          <= S_WAIT_UART_RX;
                end
                S_WAIT_UART_RX: begin
                    // An address of zero means nothing arrived yet, so keep waiting.
                    if (uart_timer == UART_LIMIT && UART_SRAM_address != '0) begin
                        UART_rx_initialize <= 1'b1;
                        stage_idx          <= '0;
                        state              <= S_STAGE_SELECT;
                    end
                end
                S_STAGE_SELECT: begin
                    if (!sel_valid) begin
                        VGA_enable <= 1'b1;
                        state      <= S_IDLE;
                    end else if (!Stage_enable_mask[sel]) begin
                        stage_idx <= stage_idx + 4'd1;
                    end else begin
                        Stage_start <= NUM_STAGES'(1) << sel;
                        wd_timer    <= '0;
                        state       <= S_STAGE_WAIT;
                    end
                end
                S_STAGE_WAIT: begin
                    if (Stage_stop[sel]) begin
                        stage_idx <= stage_idx + 4'd1;
                        state     <= S_STAGE_SELECT;
                    end else if (WD_ON && wd_timer == WD_LIMIT) begin
                        Stage_timeout_error <= 1'b1;
                        Error_stage         <= stage_idx[2:0];
                        VGA_enable          <= 1'b1;
                        state               <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        SRAM_address    = VGA_SRAM_address;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (state)
            S_ENABLE_UART_RX, S_WAIT_UART_RX: begin
                SRAM_address    = UART_SRAM_address;
                SRAM_write_data = UART_SRAM_write_data;
                SRAM_we_n       = UART_SRAM_we_n;
            end
            S_STAGE_WAIT: begin
                SRAM_address    = st_addr[sel];
                SRAM_write_data = st_data[sel];
                SRAM_we_n       = Stage_SRAM_we_n[sel];
            end
            S_STAGE_SELECT: begin
                if (sel_valid) begin
                    SRAM_address = st_addr[sel];
                end
            end
            default: ;
        endcase
    end

endmodule
